// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the tick generator.
// Divisor constants assume a 256 Hz board clock.
package tick_gen_pkg;

    // Default width of each channel counter and divisor field.
    localparam int CNT_W_DEFAULT = 9;

    // Divisors producing common rates from the 256 Hz clock.
    localparam int DIV_1HZ = 256;
    localparam int DIV_2HZ = 128;
    localparam int DIV_4HZ = 64;

    // Fast-mode divisor: scale down by 2^shift, never below 1 for a
    // non-zero divisor. A zero divisor stays zero and keeps its channel off.
    function automatic int unsigned fast_divisor(input int unsigned value,
                                                 input int unsigned shift);
        int unsigned scaled;
        scaled = value >> shift;
        if (value == 0) begin
            return 0;
        end
        if (scaled == 0) begin
            return 1;
        end
        return scaled;
    endfunction

endpackage

// File: rtl/tick_gen_channel.sv
// One divider channel: a period counter, a shadow divisor that only
// changes at period boundaries, and registered clk_out / tick outputs.
// The outputs describe the counter position of the previous edge, so
// clk_out is low for ceil(D/2) cycles, then high for floor(D/2) cycles,
// and tick coincides with the last cycle of each period.
module tick_gen_channel #(
    parameter int CNT_W = 9
) (
    input  logic             clk_256Hz,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync_clr,
    input  logic [CNT_W-1:0] load_div,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow_div;
    logic [CNT_W-1:0] half;
    logic             wrap;

    // First count at which clk_out goes high: ceil(D/2) without overflow.
    assign half = (shadow_div >> 1) + {{(CNT_W-1){1'b0}}, shadow_div[0]};
    assign wrap = (cnt == shadow_div - CNT_W'(1));

    // Counter, shadow divisor and registered outputs; reset > sync_clr > enable.
    always_ff @(posedge clk_256Hz) begin
        // NOTE: non-blocking assignments so every register here sees the
        // pre-edge values of cnt and shadow_div, whatever the statement order.
        if (!reset || sync_clr || shadow_div == '0) begin
            // A zero divisor parks the channel and keeps sampling div
            // every cycle until a non-zero value arrives.
            cnt        <= '0;
            shadow_div <= load_div;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else if (enable) begin
            tick    <= wrap;
            clk_out <= (cnt >= half);
            if (wrap) begin
                cnt        <= '0;
                shadow_div <= load_div;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            // Disabled: counter and clk_out hold, tick is suppressed.
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_generator.sv
// Multi-channel tick generator running from the 256 Hz board clock.
// Each channel divides the clock by its own divisor field of div.
// Optional feature: define TICK_GEN_FAST_EN to add the 'fast' input,
// which scales reloaded divisors down by 2^FAST_SHIFT (minimum 1).
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int          NUM_CH     = 3,
    parameter int          CNT_W      = CNT_W_DEFAULT,
    parameter int unsigned FAST_SHIFT = 4
) (
    input  logic                    clk_256Hz,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    sync_clr,
`ifdef TICK_GEN_FAST_EN
    input  logic                    fast,
`endif
    input  logic [NUM_CH*CNT_W-1:0] div,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick
);

    // Elaboration-time guard on the supported configuration range.
    if (NUM_CH < 1 || NUM_CH > 8 || CNT_W < 1 || FAST_SHIFT > 31) begin : g_bad_params
        $error("tick_generator: unsupported NUM_CH/CNT_W/FAST_SHIFT");
    end

    // One independent divider per channel, sharing only the control inputs.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] field;
        logic [CNT_W-1:0] load_div;

        assign field = div[i*CNT_W +: CNT_W];

`ifdef TICK_GEN_FAST_EN
        assign load_div = fast ? CNT_W'(fast_divisor(32'(field), FAST_SHIFT)) : field;
`else
        assign load_div = field;
`endif

        tick_gen_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clk_256Hz (clk_256Hz),
            .reset     (reset),
            .enable    (enable),
            .sync_clr  (sync_clr),
            .load_div  (load_div),
            .clk_out   (clk_out[i]),
            .tick      (tick[i])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// Self-checking bench for tick_generator: directed period/duty scenarios
// plus a randomized run compared against a behavioural model that tracks
// each channel's position within its current period.
// Optional feature: TICK_GEN_FAST_EN (adds the fast-mode scenario).
module tb_tick_generator;
    import tick_gen_pkg::*;

    localparam int NUM_CH     = 3;
    localparam int CNT_W      = CNT_W_DEFAULT;
    localparam int FAST_SHIFT = 4;

    logic                    clk_256Hz = 1'b0;
    logic                    reset     = 1'b0;
    logic                    enable    = 1'b0;
    logic                    sync_clr  = 1'b0;
    logic                    fast_mode = 1'b0;
    logic [NUM_CH*CNT_W-1:0] div       = '0;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: period length and enabled edges elapsed in it.
    int unsigned       m_per [NUM_CH];
    int unsigned       m_pos [NUM_CH];
    logic [NUM_CH-1:0] m_clk  = '0;
    logic [NUM_CH-1:0] m_tick = '0;
    int                tick_sum [NUM_CH];
    int                hi_sum   [NUM_CH];

    tick_generator #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .FAST_SHIFT (FAST_SHIFT)
    ) dut (
        .clk_256Hz (clk_256Hz),
        .reset     (reset),
        .enable    (enable),
        .sync_clr  (sync_clr),
`ifdef TICK_GEN_FAST_EN
        .fast      (fast_mode),
`endif
        .div       (div),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    initial forever #5 clk_256Hz = ~clk_256Hz;

    task automatic set_div(input int ch, input int unsigned v);
        div[ch*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    // Advance one clock edge; the model consumes the inputs applied to it.
    task automatic cycle();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            int unsigned field;
            int unsigned load;
            field = 32'(div[ch*CNT_W +: CNT_W]);
            load  = field;
            if (fast_mode && field != 0) begin
                load = ((field >> FAST_SHIFT) == 0) ? 1 : (field >> FAST_SHIFT);
            end
            if (!reset || sync_clr || m_per[ch] == 0) begin
                m_per[ch]  = load;
                m_pos[ch]  = 0;
                m_clk[ch]  = 1'b0;
                m_tick[ch] = 1'b0;
            end else if (enable) begin
                m_pos[ch]  = m_pos[ch] + 1;
                // Low for the first ceil(P/2) positions of a period, high after.
                m_clk[ch]  = (2 * m_pos[ch] > m_per[ch] + 1);
                m_tick[ch] = (m_pos[ch] == m_per[ch]);
                if (m_tick[ch]) begin
                    m_pos[ch] = 0;
                    m_per[ch] = load;
                end
            end else begin
                m_tick[ch] = 1'b0;
            end
        end
        @(posedge clk_256Hz);
        #1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            tick_sum[ch] += 32'(tick[ch]);
            hi_sum[ch]   += 32'(clk_out[ch]);
        end
    endtask

    // Run until tick[ch] is seen or the budget expires; n is cycles taken.
    task automatic wait_tick(input int ch, input int budget, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (tick[ch] !== 1'b1 && n < budget);
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        enable = 1'b1;
        set_div(0, DIV_1HZ);
        set_div(1, 5);
        set_div(2, 0);
        for (int k = 0; k < 2; k++) begin
            cycle();
            vectors++;
            if (clk_out !== '0 || tick !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: clk_out=%b tick=%b expected 000/000", clk_out, tick);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_one_hz();
        int n;
        int errs;
        wait_tick(0, 600, n);
        vectors++;
        if (n !== 256) begin
            miscompares++;
            $display("FAIL first_tick_1hz: after %0d cycles, expected 256", n);
        end
        errs = 0;
        for (int j = 1; j <= 256; j++) begin
            cycle();
            if (clk_out[0] !== (j > 128) || tick[0] !== (j == 256)) errs++;
        end
        vectors++;
        if (errs !== 0) begin
            miscompares++;
            $display("FAIL duty_1hz: %0d bad cycles, expected 0 (128 low, 128 high)", errs);
        end
    endtask

    task automatic test_odd_divisor();
        int n;
        int errs;
        wait_tick(1, 20, n);
        errs = 0;
        for (int j = 1; j <= 10; j++) begin
            int p;
            p = (j - 1) % 5 + 1;
            cycle();
            if (clk_out[1] !== (p > 3) || tick[1] !== (p == 5)) errs++;
        end
        vectors++;
        if (errs !== 0) begin
            miscompares++;
            $display("FAIL duty_div5: %0d bad cycles, expected 0 (3 low, 2 high)", errs);
        end
    endtask

    task automatic test_div_change();
        int n;
        wait_tick(0, 600, n);
        repeat (50) cycle();
        set_div(0, DIV_2HZ);
        wait_tick(0, 600, n);
        vectors++;
        if (n !== 206) begin
            miscompares++;
            $display("FAIL div_change_current: tick after %0d cycles, expected 206", n);
        end
        for (int k = 0; k < 2; k++) begin
            wait_tick(0, 600, n);
            vectors++;
            if (n !== 128) begin
                miscompares++;
                $display("FAIL div_change_next: period %0d, expected 128", n);
            end
        end
    endtask

    task automatic test_enable_gap();
        int n;
        repeat (100) cycle();
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            vectors++;
            if (tick !== '0 || clk_out[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL enable_freeze: tick=%b clk_out0=%b expected 000/1", tick, clk_out[0]);
            end
        end
        enable = 1'b1;
        wait_tick(0, 600, n);
        vectors++;
        if (n !== 28) begin
            miscompares++;
            $display("FAIL enable_late_tick: tick after %0d cycles, expected 28", n);
        end
    endtask

    task automatic test_reset_and_clear();
        int n;
        set_div(0, DIV_1HZ);
        wait_tick(0, 600, n);
        repeat (200) cycle();
        reset = 1'b0;
        cycle();
        vectors++;
        if (clk_out !== '0 || tick !== '0) begin
            miscompares++;
            $display("FAIL midperiod_reset: clk_out=%b tick=%b expected 000/000", clk_out, tick);
        end
        reset = 1'b1;
        wait_tick(1, 20, n);
        vectors++;
        if (n !== 5) begin
            miscompares++;
            $display("FAIL restart_after_reset: ch1 tick after %0d cycles, expected 5", n);
        end
        repeat (25) cycle();
        sync_clr = 1'b1;
        cycle();
        vectors++;
        if (clk_out !== '0 || tick !== '0) begin
            miscompares++;
            $display("FAIL sync_clr_outputs: clk_out=%b tick=%b expected 000/000", clk_out, tick);
        end
        sync_clr = 1'b0;
        wait_tick(0, 600, n);
        vectors++;
        if (n !== 256) begin
            miscompares++;
            $display("FAIL restart_after_clr: tick after %0d cycles, expected 256", n);
        end
        vectors++;
        if (tick_sum[2] !== 0 || hi_sum[2] !== 0) begin
            miscompares++;
            $display("FAIL div0_silent: ticks=%0d high=%0d expected 0/0", tick_sum[2], hi_sum[2]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        set_div(1, 1);
        wait_tick(1, 20, n);
        for (int k = 0; k < 8; k++) begin
            cycle();
            vectors++;
            if (tick[1] !== 1'b1 || clk_out[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL div1_every_cycle: tick1=%b clk_out1=%b expected 1/0", tick[1], clk_out[1]);
            end
        end
    endtask

`ifdef TICK_GEN_FAST_EN
    task automatic test_fast();
        int n;
        fast_mode = 1'b1;
        set_div(0, DIV_1HZ);
        set_div(1, 8);
        wait_tick(0, 600, n);
        for (int k = 0; k < 2; k++) begin
            wait_tick(0, 600, n);
            vectors++;
            if (n !== 16) begin
                miscompares++;
                $display("FAIL fast_period: period %0d, expected 16", n);
            end
        end
        for (int k = 0; k < 4; k++) begin
            cycle();
            vectors++;
            if (tick[1] !== 1'b1) begin
                miscompares++;
                $display("FAIL fast_div8: tick1=%b expected 1", tick[1]);
            end
        end
        fast_mode = 1'b0;
    endtask
`endif

    task automatic test_random();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                int unsigned v;
                case ($urandom_range(0, 5))
                    0:       v = 0;
                    1:       v = 1;
                    2:       v = $urandom_range(2, 12);
                    3:       v = $urandom_range(13, 40);
                    4:       v = DIV_4HZ;
                    default: v = $urandom_range(0, 511);
                endcase
                set_div(int'($urandom_range(0, NUM_CH - 1)), v);
            end
            reset    = ($urandom_range(0, 199) != 0);
            sync_clr = ($urandom_range(0, 63) == 0);
            enable   = ($urandom_range(0, 9) != 0);
`ifdef TICK_GEN_FAST_EN
            if ($urandom_range(0, 63) == 0) fast_mode = ~fast_mode;
`endif
            cycle();
            vectors++;
            if (clk_out !== m_clk || tick !== m_tick) begin
                miscompares++;
                $display("FAIL random_vs_model: cycle %0d clk_out=%b tick=%b expected %b/%b",
                         k, clk_out, tick, m_clk, m_tick);
            end
        end
        reset    = 1'b1;
        sync_clr = 1'b0;
        enable   = 1'b1;
    endtask

    initial begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_per[ch]    = 0;
            m_pos[ch]    = 0;
            tick_sum[ch] = 0;
            hi_sum[ch]   = 0;
        end
        test_reset();
        test_one_hz();
        test_odd_divisor();
        test_div_change();
        test_enable_gap();
        test_reset_and_clear();
        test_back_to_back();
`ifdef TICK_GEN_FAST_EN
        test_fast();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
